// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master clock/strobe controller.
package spi_pkg;

   localparam int DEF_DWIDTH = 8;
   localparam int SPR_W      = 2;
   localparam int EDGES      = 2 * DEF_DWIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } spi_state_e;

   // SCK half-period in system clocks for a given baud select.
   function automatic int unsigned spr_to_half(input logic [SPR_W-1:0] spr);
      return 32'd1 << spr;
   endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period down-counter: one-cycle tick every (reload+1) clocks while enabled.
module spi_baud_gen #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          en,
   input  logic [CW-1:0] reload,
   output logic          tick
);

   logic [CW-1:0] cnt_r;

   assign tick = en && (cnt_r == {CW{1'b0}});

   // Counter: load wins, then reload on tick, else count down while enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (load) begin
         cnt_r <= reload;
      end else if (tick) begin
         cnt_r <= reload;
      end else if (en) begin
         cnt_r <= cnt_r - CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/spi_clk_ctrl.sv
// SPI master transfer controller: generates SCK, SS_n and the shifter strobes,
// tracks the edge count and maintains the SPIF/WCOL status flags.
module spi_clk_ctrl #(
   parameter int DWIDTH = spi_pkg::DEF_DWIDTH,
   parameter int SPR_W  = spi_pkg::SPR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             SPE,
   input  logic             CPOL,
   input  logic             CPHA,
   input  logic [SPR_W-1:0] SPR,
   input  logic             SPDR_wr_en,
   input  logic             SPIF_clr,
   output logic             SCK,
   output logic             SS_n,
   output logic             Shift_en,
   output logic             Sample_en,
   output logic             Busy,
   output logic             SPIF,
   output logic             WCOL
);

   import spi_pkg::*;

   localparam int CW       = (1 << SPR_W) - 1;
   localparam int ECW      = $clog2(2 * DWIDTH) + 1;
   localparam int EDGE_CNT = EDGES * DWIDTH / DEF_DWIDTH;
   localparam logic [ECW-1:0] EDGE_LAST = ECW'(EDGE_CNT);
   localparam logic [ECW-1:0] EDGE_PEN  = ECW'(EDGE_CNT - 1);

   spi_state_e       state_r, state_s;
   logic             first_r, first_s;
   logic [ECW-1:0]   edge_cnt_r, edge_cnt_s;
   logic             cpol_lat_r, cpol_lat_s;
   logic             cpha_lat_r, cpha_lat_s;
   logic [SPR_W-1:0] spr_lat_r, spr_lat_s;
   logic             sck_r, sck_s, ss_n_r, ss_n_s, shift_r, shift_s;
   logic             sample_r, sample_s, busy_r, busy_s;
   logic             spif_r, spif_s, wcol_r, wcol_s;
   logic             baud_load_s, baud_en_s, tick_s, leading_s;
   logic [CW-1:0]    reload_s;

   assign reload_s  = CW'(spr_to_half(spr_lat_r) - 32'd1);
   assign leading_s = ~edge_cnt_r[0];

   spi_baud_gen #(.CW(CW)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (baud_load_s),
      .en     (baud_en_s),
      .reload (reload_s),
      .tick   (tick_s)
   );

   // State, config latches and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         first_r    <= 1'b0;
         edge_cnt_r <= {ECW{1'b0}};
         cpol_lat_r <= 1'b0;
         cpha_lat_r <= 1'b0;
         spr_lat_r  <= {SPR_W{1'b0}};
         sck_r      <= 1'b0;
         ss_n_r     <= 1'b1;
         shift_r    <= 1'b0;
         sample_r   <= 1'b0;
         busy_r     <= 1'b0;
         spif_r     <= 1'b0;
         wcol_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         first_r    <= first_s;
         edge_cnt_r <= edge_cnt_s;
         cpol_lat_r <= cpol_lat_s;
         cpha_lat_r <= cpha_lat_s;
         spr_lat_r  <= spr_lat_s;
         sck_r      <= sck_s;
         ss_n_r     <= ss_n_s;
         shift_r    <= shift_s;
         sample_r   <= sample_s;
         busy_r     <= busy_s;
         spif_r     <= spif_s;
         wcol_r     <= wcol_s;
      end
   end

   // Next-state and next-output logic; flag sets take priority over SPIF_clr.
   always_comb begin
      state_s     = state_r;
      first_s     = 1'b0;
      edge_cnt_s  = edge_cnt_r;
      cpol_lat_s  = cpol_lat_r;
      cpha_lat_s  = cpha_lat_r;
      spr_lat_s   = spr_lat_r;
      sck_s       = sck_r;
      ss_n_s      = ss_n_r;
      shift_s     = 1'b0;
      sample_s    = 1'b0;
      busy_s      = busy_r;
      spif_s      = spif_r;
      wcol_s      = wcol_r;
      baud_load_s = 1'b0;
      baud_en_s   = 1'b0;

      if (SPIF_clr) begin
         spif_s = 1'b0;
         wcol_s = 1'b0;
      end else begin
         spif_s = spif_r;
      end
      if (SPDR_wr_en && busy_r) begin
         wcol_s = 1'b1;
      end else begin
         wcol_s = wcol_s;
      end

      case (state_r)
         IDLE: begin
            sck_s  = CPOL;
            ss_n_s = 1'b1;
            busy_s = 1'b0;
            if (SPDR_wr_en && SPE) begin
               state_s    = ACTIVE;
               first_s    = 1'b1;
               edge_cnt_s = {ECW{1'b0}};
               cpol_lat_s = CPOL;
               cpha_lat_s = CPHA;
               spr_lat_s  = SPR;
            end else begin
               state_s = IDLE;
            end
         end
         ACTIVE: begin
            if (!SPE) begin
               state_s = IDLE;
               sck_s   = CPOL;
               ss_n_s  = 1'b1;
               busy_s  = 1'b0;
            end else if (first_r) begin
               busy_s      = 1'b1;
               ss_n_s      = 1'b0;
               sck_s       = cpol_lat_r;
               spif_s      = 1'b0;
               shift_s     = ~cpha_lat_r;
               baud_load_s = 1'b1;
            end else begin
               baud_en_s = 1'b1;
               if (tick_s && (edge_cnt_r == EDGE_LAST)) begin
                  state_s = DONE;
               end else if (tick_s) begin
                  edge_cnt_s = edge_cnt_r + ECW'(1);
                  sck_s      = ~sck_r;
                  if (cpha_lat_r) begin
                     shift_s  = leading_s;
                     sample_s = ~leading_s;
                  end else begin
                     // No shift on the final trailing edge: all bits are out.
                     sample_s = leading_s;
                     shift_s  = ~leading_s && (edge_cnt_r != EDGE_PEN);
                  end
               end else begin
                  state_s = ACTIVE;
               end
            end
         end
         DONE: begin
            state_s = IDLE;
            ss_n_s  = 1'b1;
            busy_s  = 1'b0;
            spif_s  = 1'b1;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign SCK       = sck_r;
   assign SS_n      = ss_n_r;
   assign Shift_en  = shift_r;
   assign Sample_en = sample_r;
   assign Busy      = busy_r;
   assign SPIF      = spif_r;
   assign WCOL      = wcol_r;

endmodule

// File: tb/tb_spi_clk_ctrl.sv
// Self-checking bench for spi_clk_ctrl against a cycle-offset arithmetic model.
module tb_spi_clk_ctrl;

   localparam int DW = 8;
   localparam int E2 = 2 * DW;

   logic       clk = 1'b0;
   logic       rst_n, SPE, CPOL, CPHA, SPDR_wr_en, SPIF_clr;
   logic [1:0] SPR;
   logic       SCK, SS_n, Shift_en, Sample_en, Busy, SPIF, WCOL;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   spi_clk_ctrl #(.DWIDTH(DW), .SPR_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .SPE(SPE), .CPOL(CPOL), .CPHA(CPHA), .SPR(SPR),
      .SPDR_wr_en(SPDR_wr_en), .SPIF_clr(SPIF_clr), .SCK(SCK), .SS_n(SS_n),
      .Shift_en(Shift_en), .Sample_en(Sample_en), .Busy(Busy), .SPIF(SPIF), .WCOL(WCOL)
   );

   // Expected {SCK,SS_n,Shift_en,Sample_en,Busy,SPIF} n clocks after the start edge.
   function automatic logic [5:0] model(input int n, input bit cpol, input bit cpha, input int h);
      int   last, ed, k;
      logic busy, sck, sh, sa;
      last = (E2 + 1) * h + 1;
      busy = (n >= 1 && n <= last);
      ed   = (n - 1) / h;
      if (ed > E2) ed = E2;
      sck  = cpol ^ ed[0];
      k    = (n >= 2 && (n - 1) % h == 0 && (n - 1) / h <= E2) ? (n - 1) / h : 0;
      if (!cpha) begin
         sh = (n == 1) || (k >= 2 && k % 2 == 0 && k <= E2 - 2);
         sa = (k % 2 == 1);
      end else begin
         sh = (k % 2 == 1);
         sa = (k >= 2 && k % 2 == 0);
      end
      return {sck, ~busy, sh, sa, busy, (n > last)};
   endfunction

   // One transfer; optional collision write, config change or SPE drop after observation n.
   task automatic xfer(input bit cpol, input bit cpha, input int spr, input int collide_n,
                       input int chg_n, input int drop_n, input string nm);
      int         h, total, togg, nsh, nsa;
      logic       prev_sck, ewcol;
      logic [5:0] obs, exp;
      h = 1 << spr;
      total = (E2 + 1) * h + 2;
      togg = 0; nsh = 0; nsa = 0;
      CPOL = cpol; CPHA = cpha; SPR = spr[1:0]; SPE = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (SCK !== cpol) begin
         errors++;
         $display("FAIL %s idle_sck: got %b want %b", nm, SCK, cpol);
      end
      prev_sck = SCK;
      SPDR_wr_en = 1'b1; SPIF_clr = 1'b1;
      @(posedge clk); #1;
      SPDR_wr_en = 1'b0; SPIF_clr = 1'b0;
      for (int n = 1; n <= total; n++) begin
         @(posedge clk); #1;
         if (drop_n > 0 && n > drop_n) exp = {cpol, 1'b1, 4'b0000};
         else exp = model(n, cpol, cpha, h);
         ewcol = (collide_n > 0 && n > collide_n);
         obs = {SCK, SS_n, Shift_en, Sample_en, Busy, SPIF};
         checks++;
         if (obs !== exp || WCOL !== ewcol) begin
            errors++;
            $display("FAIL %s cyc t0+%0d: got sck/ssn/sh/sa/busy/spif=%b wcol=%b want %b wcol=%b",
                     nm, n, obs, WCOL, exp, ewcol);
         end
         if (SCK !== prev_sck) togg++;
         prev_sck = SCK;
         nsh += int'(Shift_en);
         nsa += int'(Sample_en);
         SPDR_wr_en = (n == collide_n);
         if (n == chg_n) begin
            CPHA = ~cpha;
            SPR  = SPR + 2'd1;
         end
         if (drop_n > 0 && n == drop_n) SPE = 1'b0;
      end
      SPDR_wr_en = 1'b0;
      if (drop_n == 0) begin
         checks++;
         if (togg != E2 || nsh != DW || nsa != DW) begin
            errors++;
            $display("FAIL %s counts: got edges=%0d shift=%0d sample=%0d want %0d/%0d/%0d",
                     nm, togg, nsh, nsa, E2, DW, DW);
         end
      end
      SPE = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if ({SCK, SS_n, Shift_en, Sample_en, Busy, SPIF, WCOL} !== 7'b0100000) begin
         errors++;
         $display("FAIL reset_values: got %b want 0100000",
                  {SCK, SS_n, Shift_en, Sample_en, Busy, SPIF, WCOL});
      end
   endtask

   task automatic test_idle_cpol();
      for (int i = 0; i < 4; i++) begin
         CPOL = ~CPOL;
         @(posedge clk); #1;
         checks++;
         if (SCK !== CPOL) begin
            errors++;
            $display("FAIL idle_cpol_follow: got %b want %b", SCK, CPOL);
         end
      end
   endtask

   task automatic test_basic();
      xfer(1'b0, 1'b0, 0, 0, 0, 0, "spr0_mode0");
      xfer(1'b1, 1'b1, 2, 0, 0, 0, "spr2_mode3");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         xfer(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(3)), 0, 0, 0, "random");
      end
   endtask

   task automatic test_collision();
      xfer(1'b0, 1'b1, 1, 17, 0, 0, "collision");
      SPIF_clr = 1'b1;
      @(posedge clk); #1;
      SPIF_clr = 1'b0;
      checks++;
      if (SPIF !== 1'b0 || WCOL !== 1'b0) begin
         errors++;
         $display("FAIL flag_clear: got spif=%b wcol=%b want 0 0", SPIF, WCOL);
      end
   endtask

   task automatic test_abort();
      xfer(1'b1, 1'b0, 1, 0, 0, 1 + 5 * 2, "abort_spr1");
      xfer(1'b0, 1'b1, 0, 0, 0, 1 + 5, "abort_spr0");
   endtask

   task automatic test_reset_mid();
      CPOL = 1'b1; CPHA = 1'b0; SPR = 2'd1; SPE = 1'b1;
      SPDR_wr_en = 1'b1;
      @(posedge clk); #1;
      SPDR_wr_en = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      xfer(1'b1, 1'b0, 1, 0, 0, 0, "after_reset");
   endtask

   task automatic test_cfg_change();
      xfer(1'b0, 1'b0, 1, 0, 20, 0, "cfg_change");
      xfer(1'b0, 1'b1, 2, 0, 0, 0, "cfg_next");
   endtask

   initial begin
      rst_n = 1'b0; SPE = 1'b0; CPOL = 1'b0; CPHA = 1'b0; SPR = 2'd0;
      SPDR_wr_en = 1'b0; SPIF_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_idle_cpol();
      test_basic();
      test_random();
      test_collision();
      test_abort();
      test_reset_mid();
      test_cfg_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
